// File: rtl/vga_sync_font_rom.sv
// 640x480@60 VGA sync/pixel-coordinate generator with a synchronous 8x16 digit font ROM.
// Optional VGASYNC_VIDEO_ON_EN adds a registered active-area flag (video_on_o).
module vga_sync_font_rom #(
   parameter int unsigned H_DISPLAY = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_DISPLAY = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic [9:0]  pixel_x_o,
   output logic [9:0]  pixel_y_o,
   input  logic [10:0] addr,
   output logic [7:0]  data
`ifdef VGASYNC_VIDEO_ON_EN
   ,
   output logic        video_on_o
`endif
);

   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
   localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);
`ifdef VGASYNC_VIDEO_ON_EN
   localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
`endif

   logic [9:0] x_nxt;
   logic [9:0] y_nxt;
   logic       hsync_nxt;
   logic       vsync_nxt;

   // Next-state counters; sync flags decode the next state so they line up with the counters.
   always_comb begin
      x_nxt = pixel_x_o + 10'd1;
      y_nxt = pixel_y_o;
      if (pixel_x_o == H_MAX) begin
         x_nxt = 10'd0;
         y_nxt = (pixel_y_o == V_MAX) ? 10'd0 : pixel_y_o + 10'd1;
      end
      hsync_nxt = !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vsync_nxt = !((y_nxt >= VS_START) && (y_nxt < VS_END));
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pixel_x_o <= 10'd0;
         pixel_y_o <= 10'd0;
         hsync_o   <= 1'b1;
         vsync_o   <= 1'b1;
      end else begin
         pixel_x_o <= x_nxt;
         pixel_y_o <= y_nxt;
         hsync_o   <= hsync_nxt;
         vsync_o   <= vsync_nxt;
      end
   end

`ifdef VGASYNC_VIDEO_ON_EN
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) video_on_o <= 1'b0;
      else         video_on_o <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
   end
`endif

   logic [79:0] glyph;
   logic [3:0]  row;
   logic [3:0]  row_idx;
   logic [6:0]  bit_lo;
   logic [7:0]  rom_row;

   // Glyph rows 2..11 packed MSB-first (row 2 in bits 79:72); all other rows are blank.
   always_comb begin
      glyph   = 80'h0;
      row     = addr[3:0];
      row_idx = 4'd11 - row;
      bit_lo  = {row_idx, 3'b000};
      rom_row = 8'h00;
      case (addr[10:4])
         7'h30:   glyph = 80'h7CC6C6CEDEF6E6C6C67C;
         7'h31:   glyph = 80'h1838781818181818187E;
         7'h32:   glyph = 80'h7CC6060C183060C0C6FE;
         7'h33:   glyph = 80'h7CC606063C060606C67C;
         7'h34:   glyph = 80'h0C1C3C6CCCFE0C0C0C1E;
         7'h35:   glyph = 80'hFEC0C0C0FC060606C67C;
         7'h36:   glyph = 80'h3860C0C0FCC6C6C6C67C;
         7'h37:   glyph = 80'hFEC606060C1830303030;
         7'h38:   glyph = 80'h7CC6C6C67CC6C6C6C67C;
         7'h39:   glyph = 80'h7CC6C6C67E0606060C78;
         default: glyph = 80'h0;
      endcase
      if ((row >= 4'd2) && (row <= 4'd11)) rom_row = glyph[bit_lo +: 8];
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) data <= 8'h00;
      else         data <= rom_row;
   end

endmodule

// File: tb/tb_vga_sync_font_rom.sv
// Directed bench for vga_sync_font_rom: full-size timing instance plus a short-frame
// instance (12 lines) so vertical sync and frame wrap are reached quickly.
module tb_vga_sync_font_rom;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [10:0] addr;

   logic        hs1, vs1, hs2, vs2;
   logic [9:0]  x1, y1, x2, y2;
   logic [7:0]  d1, d2;
`ifdef VGASYNC_VIDEO_ON_EN
   logic        vo1, vo2;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #20 clk = ~clk;

   vga_sync_font_rom u_dut (
      .clk_i(clk), .reset_i(reset_i), .hsync_o(hs1), .vsync_o(vs1),
      .pixel_x_o(x1), .pixel_y_o(y1), .addr(addr), .data(d1)
`ifdef VGASYNC_VIDEO_ON_EN
      , .video_on_o(vo1)
`endif
   );

   vga_sync_font_rom #(
      .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_short (
      .clk_i(clk), .reset_i(reset_i), .hsync_o(hs2), .vsync_o(vs2),
      .pixel_x_o(x2), .pixel_y_o(y2), .addr(addr), .data(d2)
`ifdef VGASYNC_VIDEO_ON_EN
      , .video_on_o(vo2)
`endif
   );

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 time unit past the last one.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
      end
      #1;
   endtask

   typedef struct { logic [10:0] a; logic [7:0] exp; } rom_vec_t;
   rom_vec_t rv[10];

   int vs_low;
   int hs_low_in_vs;

   initial begin
      rv[0] = '{11'h302, 8'h7C};
      rv[1] = '{11'h312, 8'h18};
      rv[2] = '{11'h31B, 8'h7E};
      rv[3] = '{11'h395, 8'hC6};
      rv[4] = '{11'h000, 8'h00};
      rv[5] = '{11'h41F, 8'h00};
      rv[6] = '{11'h380, 8'h00};
      rv[7] = '{11'h30C, 8'h00};
      rv[8] = '{11'h2F6, 8'h00};
      rv[9] = '{11'h347, 8'hFE};

      reset_i = 1'b1;
      addr    = 11'h302;
      step(3);
      chk("rom_in_reset", d1, 8'h00);
      chk("rst_x", x1, 0);
      chk("rst_y", y1, 0);
      chk("rst_hs", hs1, 1);
      chk("rst_vs", vs1, 1);
`ifdef VGASYNC_VIDEO_ON_EN
      chk("rst_von", vo1, 0);
`endif

      reset_i = 1'b0;
      cyc = 0;
      chk("rel_x", x1, 0);
      chk("rel_data", d1, 8'h00);

      // Horizontal sync edges and line wrap
      step(655);
      chk("x655", x1, 655);
      chk("hs_655", hs1, 1);
      step(1);
      chk("x656", x1, 656);
      chk("hs_656", hs1, 0);
      step(95);
      chk("hs_751", hs1, 0);
      step(1);
      chk("x752", x1, 752);
      chk("hs_752", hs1, 1);
      step(47);
      chk("x799", x1, 799);
      chk("y_before_wrap", y1, 0);
      step(1);
      chk("wrap_x", x1, 0);
      chk("wrap_y", y1, 1);

      // Font ROM, one address per cycle
      for (int i = 0; i < 10; i++) begin
         addr = rv[i].a;
         step(1);
         chk($sformatf("rom_%03h", rv[i].a), d1, rv[i].exp);
      end

      // Asynchronous reset mid-hsync at (700,1)
      step(1500 - cyc);
      chk("pre_rst_x", x1, 700);
      chk("pre_rst_hs", hs1, 0);
      chk("pre_rst_data", d1, 8'hFE);
      #5 reset_i = 1'b1;
      #1;
      chk("arst_x", x1, 0);
      chk("arst_y", y1, 0);
      chk("arst_hs", hs1, 1);
      chk("arst_data", d1, 8'h00);
      step(2);
      reset_i = 1'b0;
      cyc = 0;
      step(1);
      chk("resume_x", x1, 1);
      chk("resume_y", y1, 0);

`ifdef VGASYNC_VIDEO_ON_EN
      chk("von_1_0", vo2, 1);
      step(639 - cyc);
      chk("von_639_0", vo2, 1);
      step(1);
      chk("von_640_0", vo2, 0);
      step(4639 - cyc);
      chk("von_639_5", vo2, 1);
      step(4800 - cyc);
      chk("von_0_6", vo2, 0);
`endif

      // Vertical sync on the short-frame instance: low on lines 8..9
      step(6399 - cyc);
      chk("s_x799", x2, 799);
      chk("s_y7", y2, 7);
      chk("s_vs_y7", vs2, 1);
      step(1);
      chk("s_y8", y2, 8);
      chk("s_vs_y8", vs2, 0);
      vs_low = 0;
      hs_low_in_vs = 0;
      for (int i = 0; i < 2000; i++) begin
         if (!vs2) begin
            vs_low++;
            if (!hs2) hs_low_in_vs++;
         end
         step(1);
      end
      chk("vs_low_cycles", vs_low, 1600);
      chk("hs_during_vs", hs_low_in_vs, 192);
      chk("s_vs_after", vs2, 1);
      step(9599 - cyc);
      chk("s_last_y", y2, 11);
      step(1);
      chk("frame_x", x2, 0);
      chk("frame_y", y2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
